// File: rtl/morse_pkg.sv
// Shared Morse definitions: sequencer state encoding, timing units and small
// helpers used by the symbol sequencer and the upstream encoder.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MARK       = 3'd1,
    ST_SYM_GAP    = 3'd2,
    ST_LETTER_GAP = 3'd3,
    ST_WORD_GAP   = 3'd4
  } state_e;

  localparam logic [2:0] DOT_UNITS        = 3'd1;
  localparam logic [2:0] DASH_UNITS       = 3'd3;
  localparam logic [2:0] SYM_GAP_UNITS    = 3'd1;
  localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS   = 3'd4;
  localparam logic [2:0] MAX_SYMBOLS      = 3'd5;

  // Lengths above the longest Morse character are treated as full length.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > MAX_SYMBOLS) ? MAX_SYMBOLS : len;
  endfunction

  // First state of a character: word gap for non-printing characters,
  // letter gap alone for an empty pattern, otherwise its first mark.
  function automatic state_e first_state(input logic chr_vld, input logic [2:0] len);
    if (!chr_vld)        return ST_WORD_GAP;
    else if (len == 3'd0) return ST_LETTER_GAP;
    else                 return ST_MARK;
  endfunction

  // Duration of a state in Morse units; a mark depends on its symbol.
  function automatic logic [2:0] state_units(input state_e st, input logic dash);
    case (st)
      ST_MARK:       return dash ? DASH_UNITS : DOT_UNITS;
      ST_SYM_GAP:    return SYM_GAP_UNITS;
      ST_LETTER_GAP: return LETTER_GAP_UNITS;
      ST_WORD_GAP:   return WORD_GAP_UNITS;
      default:       return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Morse unit timer: divides the clock into Morse time units. Emits a
// one-cycle tick on the last cycle of every unit and counts completed units
// since the last clear. Clearing restarts both counters from zero.
module morse_unit_timer #(
  parameter int CLKS_PER_UNIT = 2_500_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Clr,
  output logic       o_Tick,
  output logic [2:0] o_Units
);

  localparam int CW = (CLKS_PER_UNIT > 1) ? $clog2(CLKS_PER_UNIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_UNIT - 1);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_units;

  assign o_Tick  = (r_cnt == LAST_CNT);
  assign o_Units = r_units;

  // Cycle counter within a unit and count of whole units elapsed.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_cnt   <= '0;
      r_units <= '0;
    end else if (i_Clr) begin
      r_cnt   <= '0;
      r_units <= '0;
    end else if (o_Tick) begin
      r_cnt   <= '0;
      r_units <= r_units + 3'd1;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Morse symbol sequencer: plays one encoded character at a time on the LED
// with standard Morse timing, holding one further character in a single
// entry buffer so text can be streamed without gaps. All outputs follow the
// internal state one cycle later, so LED, busy and done share one timeline.
module morse_symbol_sequencer
  import morse_pkg::*;
#(
  parameter int CLKS_PER_UNIT = 2_500_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Load,
  input  logic [4:0] i_Morse_Pattern,
  input  logic [2:0] i_Morse_Length,
  input  logic       i_Valid,
  output logic       o_Ready,
  output logic       o_Busy,
  output logic       o_LED,
  output logic       o_Done
);

  // Buffer slot (occupancy is control, contents are plain data)
  logic       r_buf_vld;
  logic [4:0] r_buf_pat;
  logic [2:0] r_buf_len;
  logic       r_buf_chr;

  // Character currently being played
  logic [4:0] r_act_pat;
  logic [2:0] r_act_len;
  logic [2:0] r_idx;

  state_e     r_state;
  state_e     w_state_nxt;
  logic       r_done_evt;

  logic       w_load_acc;
  logic       w_drain;
  logic       w_enter;
  logic       w_idx_inc;
  logic       w_gap_end;
  logic       w_sym;
  logic       w_tick;
  logic       w_expire;
  logic       w_timer_clr;
  logic       w_buf_vld_nxt;
  logic [2:0] w_units;
  logic [2:0] w_units_req;

  assign w_load_acc    = i_Load & o_Ready;
  assign w_sym         = r_act_pat[3'd4 - r_idx];
  assign w_units_req   = state_units(r_state, w_sym);
  assign w_expire      = w_tick && (w_units == (w_units_req - 3'd1));
  assign w_timer_clr   = w_enter || (r_state == ST_IDLE);
  assign w_buf_vld_nxt = w_load_acc | (r_buf_vld & ~w_drain);

  morse_unit_timer #(
    .CLKS_PER_UNIT (CLKS_PER_UNIT)
  ) u_timer (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Clr   (w_timer_clr),
    .o_Tick  (w_tick),
    .o_Units (w_units)
  );

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: each state ends when the timer reaches its unit count; the
  // end of a letter or word gap pulls a buffered character in directly.
  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_drain     = 1'b0;
    w_idx_inc   = 1'b0;
    w_gap_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_buf_vld) begin
          w_drain     = 1'b1;
          w_enter     = 1'b1;
          w_state_nxt = first_state(r_buf_chr, r_buf_len);
        end
      end
      ST_MARK: begin
        if (w_expire) begin
          w_enter     = 1'b1;
          w_state_nxt = ((r_idx + 3'd1) < r_act_len) ? ST_SYM_GAP : ST_LETTER_GAP;
        end
      end
      ST_SYM_GAP: begin
        if (w_expire) begin
          w_enter     = 1'b1;
          w_idx_inc   = 1'b1;
          w_state_nxt = ST_MARK;
        end
      end
      ST_LETTER_GAP, ST_WORD_GAP: begin
        if (w_expire) begin
          w_enter   = 1'b1;
          w_gap_end = 1'b1;
          if (r_buf_vld) begin
            w_drain     = 1'b1;
            w_state_nxt = first_state(r_buf_chr, r_buf_len);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_enter     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Buffer occupancy, symbol index and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_buf_vld  <= 1'b0;
      o_Ready    <= 1'b1;
      r_idx      <= 3'd0;
      r_done_evt <= 1'b0;
      o_LED      <= 1'b0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
    end else begin
      r_buf_vld  <= w_buf_vld_nxt;
      o_Ready    <= ~w_buf_vld_nxt;
      if (w_drain)        r_idx <= 3'd0;
      else if (w_idx_inc) r_idx <= r_idx + 3'd1;
      r_done_evt <= w_gap_end;
      o_LED      <= (r_state == ST_MARK);
      o_Busy     <= (r_state != ST_IDLE);
      o_Done     <= r_done_evt;
    end
  end

  // Character data: captured into the buffer on load, moved to the active
  // register when the buffer drains.
  always_ff @(posedge i_Clk) begin
    if (w_load_acc) begin
      r_buf_pat <= i_Morse_Pattern;
      r_buf_len <= clamp_len(i_Morse_Length);
      r_buf_chr <= i_Valid;
    end
    if (w_drain) begin
      r_act_pat <= r_buf_pat;
      r_act_len <= r_buf_len;
    end
  end

endmodule
